uart_line_buffer: RTL
=====================

# uart_line_buffer

Line-assembly stage directly downstream of the UART receive buffer. Pops received bytes, applies terminal line editing (backspace, control-character filtering, length limit), and on CR or LF emits the completed line as a valid/ready byte stream with a last-beat marker, for a command parser to consume. Echo to the transmitter is handled elsewhere; this block only assembles and delivers lines.

## Interface
- `MAX_LEN`, default 32: line capacity in bytes; must be at least 2.
- `LW`, default `$clog2(MAX_LEN+1)`: width of the length counter.

- `clk` input, 1 bit: system clock. All state is updated on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `rx_data` input, 8 bits: head byte of the RX buffer. Valid when `rx_empty` is 0.
- `rx_empty` input, 1 bit: RX buffer empty.
- `rx_get` output, 1 bit: pop request. A byte is consumed in any cycle where `rx_get` is 1 and `rx_empty` is 0.
- `line_data` output, 8 bits: current output byte.
- `line_valid` output, 1 bit: `line_data` is valid.
- `line_last` output, 1 bit: the current beat is the final byte of the line.
- `line_err` output, 1 bit: the line was truncated. Valid on the last beat only; 0 on all other beats.
- `line_ready` input, 1 bit: downstream accepts the beat. A beat transfers when `line_valid` and `line_ready` are both 1.
- `line_len` output, LW bits: number of bytes currently stored.

## Operation
- **Storage:** an `MAX_LEN` x 8 register array, a write index `len` (LW bits), a read index `rd` (LW bits), and a sticky `ovf` flag.
- **State machine:** two states, `S_COLLECT` and `S_EMIT`. Reset enters `S_COLLECT` with `len`=0, `rd`=0, `ovf`=0.
- **`S_COLLECT`:** `rx_get`=1 and `line_valid`=0. Each accepted byte `b` is handled as follows:
  - **Printable (0x20–0x7E):** if `len` < `MAX_LEN`, store at `mem[len]` and increment `len`. Otherwise drop the byte and set `ovf`=1.
  - **Backspace (0x08 or 0x7F):** if `len` > 0, decrement `len`; at 0, ignore. `ovf` is not cleared.
  - **CR (0x0D) or LF (0x0A):**
    - If `len` > 0, go to `S_EMIT` with `rd`=0.
    - If `len`=0, ignore the byte, so a CR LF pair produces one line. Also clear `ovf`.
  - **Any other byte:** dropped silently, including 0x80–0xFF.
- **`S_EMIT`:**
  - `rx_get`=0, so no bytes are popped.
  - Outputs: `line_valid`=1, `line_data`=`mem[rd]`, `line_last`=(`rd`==`len`-1), `line_err`=`line_last` & `ovf`.
  - On each transfer, increment `rd`.
  - On the transfer with `line_last`=1, return to `S_COLLECT` and clear `len`, `rd` and `ovf`.
- **`line_len`:** always equals `len`.

## Timing
- **Reset values:** `rx_get`=0 while `rst` is asserted; `line_valid`=0, `line_data`=0, `line_last`=0, `line_err`=0, `line_len`=0.
- **Output timing:** `rx_get` is combinational from state and `rst`. `line_*` outputs are combinational from registered state and the memory, with no dependency on `line_ready`.
- **Throughput:** one byte accepted per cycle in `S_COLLECT`.
- **Terminator latency:** a terminator accepted in cycle N gives `line_valid`=1 in cycle N+1 with byte 0.
- **Output rate:** with `line_ready` held at 1, a line of L bytes occupies cycles N+1 to N+L.
- **Return to collection:** the last transfer in cycle M gives `rx_get`=1 and `line_len`=0 in cycle M+1.
- **Backpressure:** when `line_ready`=0, `line_data`, `line_last` and `line_err` hold stable; `line_valid` does not drop until the last transfer.
- **Full buffer:** at `len`=`MAX_LEN`, printable bytes are still popped (never stall the RX buffer) and dropped. A backspace then frees one slot.
- **Reset mid-line or mid-emit:** all state clears asynchronously, a partial line is discarded, and `line_valid` falls immediately.
- **Width of `len`:** must hold `MAX_LEN` exactly. Increment happens only when `len` < `MAX_LEN`; decrement only when `len` > 0. No wrap in either direction.

## Test plan
- **Basic line:** feed "ls\r" with `line_ready`=1. Expect beats 0x6C, 0x73; `line_last`=1 on 0x73; `line_err`=0; `line_valid` rises the cycle after CR is popped; `rx_get` high again the cycle after the last beat.
- **Editing and CR LF:** feed "ab", 0x08, "c\r\n". Expect exactly one line, "ac". The LF produces no output. `line_len` reads 2 before CR.
- **Backspace and empty terminators:** feed 0x08, 0x7F, "\r\r", then "x\n". Expect one line, "x"; no output for the leading backspaces or the empty CRs.
- **Overflow (`MAX_LEN`=4):** feed "abcdefg\r". Expect beats "abcd", `line_err`=1 on 'd', and every input byte popped. A following "z\r" yields "z" with `line_err`=0.
- **Backpressure:** feed "hey\r", then toggle `line_ready` 0,0,1,0,1,1. Expect `line_data`/`line_last` held while `line_ready`=0, `rx_get`=0 with `rx_empty`=0 during emission, and exactly 3 transfers.
- **Reset mid-emit:** assert `rst` after the first beat of "abc\r". Expect `line_valid`=0 immediately and `line_len`=0. After release, "q\r" yields only "q".

Source files
------------

// File: rtl/uart_line_buffer.sv
// Line-assembly stage behind the UART RX buffer: edits incoming bytes into a line
// and replays the finished line as a valid/ready byte stream with a last-beat flag.
module uart_line_buffer #(
  parameter int MAX_LEN = 32,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_empty,
  output logic          rx_get,
  output logic [7:0]    line_data,
  output logic          line_valid,
  output logic          line_last,
  output logic          line_err,
  input  logic          line_ready,
  output logic [LW-1:0] line_len
);

  localparam int            IW      = $clog2(MAX_LEN);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE     = LW'(1);

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_EMIT    = 1'b1;

  logic [7:0]    mem [MAX_LEN];
  logic [0:0]    state;
  logic [LW-1:0] len;
  logic [LW-1:0] rd;
  logic          ovf;

  logic accept;
  logic is_print;
  logic is_bs;
  logic is_term;
  logic at_last;
  logic xfer;
  logic has_room;

  assign accept   = (state == S_COLLECT) && !rx_empty;
  assign is_print = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
  assign is_bs    = (rx_data == 8'h08) || (rx_data == 8'h7F);
  assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign has_room = (len != LEN_MAX);
  assign at_last  = (rd == len - ONE);

  assign rx_get     = !rst && (state == S_COLLECT);
  assign line_valid = (state == S_EMIT);
  assign line_last  = line_valid && at_last;
  assign line_err   = line_last && ovf;
  assign line_data  = line_valid ? mem[rd[IW-1:0]] : 8'h00;
  assign line_len   = len;
  assign xfer       = line_valid && line_ready;

  // Line storage carries no reset; only slots below len are ever read back.
  always_ff @(posedge clk) begin
    if (accept && is_print && has_room) begin
      mem[len[IW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_COLLECT;
      len   <= '0;
      rd    <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (accept) begin
            if (is_print) begin
              if (has_room) begin
                len <= len + ONE;
              end else begin
                ovf <= 1'b1;
              end
            end else if (is_bs) begin
              if (len != '0) begin
                len <= len - ONE;
              end
            end else if (is_term) begin
              // An empty terminator (e.g. LF after CR) also forgets a past overflow.
              if (len != '0) begin
                state <= S_EMIT;
                rd    <= '0;
              end else begin
                ovf <= 1'b0;
              end
            end
          end
        end
        S_EMIT: begin
          if (xfer) begin
            if (at_last) begin
              state <= S_COLLECT;
              len   <= '0;
              rd    <= '0;
              ovf   <= 1'b0;
            end else begin
              rd <= rd + ONE;
            end
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule
